// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-state data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int CNT_W = 4;

  function automatic logic [3:0] size_bytes(input size_e s);
    return 4'd1 << s;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage with per-byte write enables and a registered read port.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic                  clk,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately left unreset; only enabled lanes are written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_memory_ws.sv
// Data memory with request/response handshake and WAIT_CYCLES access latency.
// Optional: define DMEM_MISALIGN_CHECK_EN to flag misaligned accesses as errors.
module data_memory_ws
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int BYTES  = DATA_W / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e              state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [31:0]         addr_q, cur_addr;
  size_e               size_q, cur_size;
  logic                uns_q, write_q, cur_uns, cur_write;
  logic [DATA_W-1:0]   wdata_q, cur_wdata;
  logic [LANE_W-1:0]   lane_raw, align_mask, lane;
  logic [3:0]          nbytes;
  logic                oor, size_bad, misalign, err, enter_resp, accept, re, sign;
  logic [BYTES-1:0]    be, we;
  logic [DATA_W-1:0]   wdata_sh, arr_rdata, rd_sh, val_mask, ext;

  assign accept    = req_valid && (state == IDLE);
  assign req_ready = (state == IDLE);

  // A zero-wait access commits on its acceptance edge, so decode uses live inputs while idle.
  always_comb begin
    if (state == IDLE) begin
      cur_addr  = req_addr;
      cur_size  = size_e'(req_size);
      cur_uns   = req_unsigned;
      cur_write = req_write;
      cur_wdata = req_wdata;
    end else begin
      cur_addr  = addr_q;
      cur_size  = size_q;
      cur_uns   = uns_q;
      cur_write = write_q;
      cur_wdata = wdata_q;
    end
  end

  always_comb begin
    nbytes     = size_bytes(cur_size);
    lane_raw   = cur_addr[LANE_W-1:0];
    align_mask = LANE_W'(nbytes - 4'd1);
    oor        = (cur_addr >> LANE_W) >= 32'(DEPTH);
    size_bad   = nbytes > 4'(BYTES);
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign   = |(lane_raw & align_mask);
    lane       = lane_raw;
`else
    misalign   = 1'b0;
    lane       = lane_raw & ~align_mask;
`endif
    err        = oor | size_bad | misalign;
    be         = BYTES'((16'd1 << nbytes) - 16'd1) << lane;
    wdata_sh   = cur_wdata << {lane, 3'b000};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
        else           state_next = IDLE;
      end
      WAIT: begin
        if (cnt == '0) state_next = RESP;
        else           state_next = WAIT;
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
        else            state_next = RESP;
      end
      default: state_next = IDLE;
    endcase
    enter_resp = (state_next == RESP) && (state != RESP);
    we         = (enter_resp && cur_write && !err) ? be : '0;
    re         = enter_resp && !cur_write && !err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= size_e'(req_size);
        uns_q   <= req_unsigned;
        write_q <= req_write;
        wdata_q <= req_wdata;
        cnt     <= (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .addr  (cur_addr[LANE_W +: AW]),
    .we    (we),
    .wdata (wdata_sh),
    .re    (re),
    .rdata (arr_rdata)
  );

  // Lane select and extension; the latched request keeps this stable through RESP.
  always_comb begin
    rd_sh = arr_rdata >> {lane, 3'b000};
    case (cur_size)
      SZ_B:    begin val_mask = DATA_W'(8'hFF);         sign = rd_sh[7];        end
      SZ_H:    begin val_mask = DATA_W'(16'hFFFF);      sign = rd_sh[15];       end
      SZ_W:    begin val_mask = DATA_W'(32'hFFFF_FFFF); sign = rd_sh[31];       end
      default: begin val_mask = '1;                     sign = rd_sh[DATA_W-1]; end
    endcase
    ext = (rd_sh & val_mask) | ((sign && !cur_uns) ? ~val_mask : '0);
  end

  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err;
  assign resp_rdata = ((state == RESP) && !err && !write_q) ? ext : '0;

endmodule

// File: doc/data_memory_ws.md
DATA_MEMORY_WS -- requirements
Module: data_memory_ws

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 256, number of words; power of two.
REQ-003 Parameter WAIT_CYCLES, default 0, extra access latency in cycles; legal range 0..15.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword.
REQ-011 req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-012 req_wdata  input  DATA_W  store data, right-aligned.
REQ-013 resp_valid  output  1  response present.
REQ-014 resp_ready  input  1  consumer accepts response.
REQ-015 resp_rdata  output  DATA_W  load result, extended; 0 for stores and errors.
REQ-016 resp_err  output  1  access was out of range, illegal size, or misaligned.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT, and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 Handshake: a request SHALL be accepted on the cycle req_valid && req_ready, which latches address, size, signedness, data, and direction.
REQ-019 After acceptance, the FSM SHALL go IDLE->RESP when WAIT_CYCLES=0, else IDLE->WAIT; it SHALL stay in WAIT for exactly WAIT_CYCLES cycles using a 4-bit down-counter, then go to RESP.
REQ-020 resp_valid SHALL assert exactly 1+WAIT_CYCLES cycles after the acceptance edge and be 1 only in RESP.
REQ-021 RESP->IDLE SHALL occur on resp_valid && resp_ready; until then resp_rdata and resp_err SHALL hold stable.
REQ-022 No new request SHALL be accepted in the same cycle a response is retired; back-to-back throughput is one access per 2+WAIT_CYCLES cycles.
REQ-023 Word index = req_addr >> log2(DATA_W/8); byte lane = low log2(DATA_W/8) address bits.
REQ-024 Out of range (word index >= DEPTH) SHALL give resp_err=1, resp_rdata=0, and no write.
REQ-025 req_size=3 with DATA_W=32 SHALL give resp_err=1 and no write.
REQ-026 Stores SHALL write only the addressed byte lanes (byte enables), committing on the edge entering RESP; other lanes are unchanged.
REQ-027 Loads SHALL sample the array on the edge entering RESP, select lanes, and extend to DATA_W per req_unsigned.
REQ-028 req_valid while not in IDLE SHALL be ignored and SHALL NOT alter latched state.

Reset
REQ-029 rst SHALL force state IDLE, wait counter 0, req_ready=1 (outside reset), resp_valid=0, resp_rdata=0, and resp_err=0.
REQ-030 rst during WAIT or RESP SHALL abort the access; an uncommitted store SHALL NOT write.
REQ-031 Array contents SHALL NOT be reset.

Configuration
REQ-032 With DMEM_MISALIGN_CHECK_EN defined, an access whose address is not size-aligned SHALL give resp_err=1, resp_rdata=0, and no write.
REQ-033 Without DMEM_MISALIGN_CHECK_EN, the address SHALL be rounded down to size alignment and the access completes normally with no error.

Structure
REQ-034 Package dmem_pkg SHALL hold the size enum (SZ_B, SZ_H, SZ_W, SZ_D), the state enum, and the WAIT counter width constant.
REQ-035 Sub-module dmem_array SHALL hold DEPTH x DATA_W storage with a per-byte write enable and a synchronous read port; the FSM, lane selection, extension, and error logic stay in data_memory_ws.

Verification
REQ-036 The bench SHALL cover: WAIT_CYCLES=0, store word 0xDEADBEEF @0x10, then load word @0x10 -> resp_rdata=0xDEADBEEF, resp_valid 1 cycle after each accept.
REQ-037 The bench SHALL cover: WAIT_CYCLES=3, store byte 0x80 @0x13, then load byte signed @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; word @0x10 -> 0x80ADBEEF; resp_valid 4 cycles after accept.
REQ-038 The bench SHALL cover: DEPTH=256, DATA_W=32, load @0x400 -> resp_err=1, resp_rdata=0; store @0x400 leaves all words unchanged.
REQ-039 The bench SHALL cover: with DMEM_MISALIGN_CHECK_EN, half store @0x11 -> resp_err=1 and memory unchanged; without it -> the write lands at @0x10 and resp_err=0.
REQ-040 The bench SHALL cover: resp_ready held 0 for 5 cycles -> resp_valid, resp_rdata, and req_ready=0 stay stable; a second req_valid is ignored until retire.
REQ-041 The bench SHALL cover: rst asserted in WAIT of a store (WAIT_CYCLES=5) -> resp_valid=0, req_ready=1, and the target word still holds its old value.
